out_ep_ctrl: RTL and testbench

// - Routes the single SIE OUT byte stream to one of N_EPS per-endpoint OUT FIFOs.
// - Tracks packets with an FSM; the endpoint is latched at the first byte and held until EOP or error.
// - Merges FIFO NAK status with endpoint enable/halt configuration into out_nak_o / out_stall_o.
// - Sits between the SIE and the out_fifo instances, in the clk_i / clk_gate_i domain.

---
 rtl/out_ep_ctrl_pkg.sv | 21 ++
 rtl/ep_pkt_counter.sv | 26 ++
 rtl/out_ep_ctrl.sv | 156 +++++++++++++++
 tb/tb_out_ep_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/out_ep_ctrl_pkg.sv
// Shared types and constants for the OUT endpoint controller.
package out_ep_ctrl_pkg;

  localparam int EP_W    = 4;
  localparam int MAX_EPS = 15;
  localparam int STAT_W  = 16;
  localparam int SEL_N   = 2 ** EP_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    REJECT = 2'd2,
    STALL  = 2'd3
  } state_e;

  // Endpoint numbers 1..n map onto FIFOs; 0 and anything above n have no FIFO.
  function automatic logic ep_in_range(input logic [EP_W-1:0] ep, input int n);
    return (ep != {EP_W{1'b0}}) && (int'(ep) <= n);
  endfunction

endpackage

// File: rtl/ep_pkt_counter.sv
// Per-endpoint confirmed-packet counter; only used when OUT_EP_CTRL_STATS_EN is defined.
module ep_pkt_counter
  import out_ep_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  output logic [STAT_W-1:0] cnt_o
);

  logic [STAT_W-1:0] cnt_q;

  // Free-running wrap at the top of the range is intentional.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {STAT_W{1'b0}};
    end else if (inc_i) begin
      cnt_q <= cnt_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/out_ep_ctrl.sv
// Routes the SIE OUT byte stream to per-endpoint FIFOs and merges NAK/STALL status.
// Optional packet statistics are enabled with the OUT_EP_CTRL_STATS_EN macro.
module out_ep_ctrl
  import out_ep_ctrl_pkg::*;
#(
  parameter int N_EPS = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clk_gate_i,
  input  logic [EP_W-1:0]  out_ep_i,
  input  logic [7:0]       out_data_i,
  input  logic             out_valid_i,
  input  logic             out_err_i,
  input  logic             out_ready_i,
  output logic             out_nak_o,
  output logic             out_stall_o,
  input  logic [N_EPS-1:0] ep_en_i,
  input  logic [N_EPS-1:0] ep_halt_i,
  output logic [7:0]       fifo_data_o,
  output logic [N_EPS-1:0] fifo_valid_o,
  output logic [N_EPS-1:0] fifo_err_o,
  output logic [N_EPS-1:0] fifo_ready_o,
  input  logic [N_EPS-1:0] fifo_nak_i
`ifdef OUT_EP_CTRL_STATS_EN
  ,
  input  logic [EP_W-1:0]   stat_sel_i,
  output logic [STAT_W-1:0] stat_cnt_o
`endif
);

  state_e          state_q;
  logic [EP_W-1:0] ep_q;

  logic            step_s, byte_s, eop_s, err_s;
  logic [EP_W-1:0] sel_s, idx_s;
  logic [SEL_N-1:0] en_pad_s, halt_pad_s, nak_pad_s;
  logic            in_range_s, legal_s, halted_s, route_s;

  assign step_s = clk_gate_i & out_ready_i;
  assign byte_s = step_s & out_valid_i & ~out_err_i;
  assign eop_s  = step_s & ~out_valid_i & ~out_err_i;
  assign err_s  = step_s & out_err_i;

  assign sel_s      = (state_q == IDLE) ? out_ep_i : ep_q;
  assign idx_s      = sel_s - {{(EP_W-1){1'b0}}, 1'b1};
  assign en_pad_s   = SEL_N'(ep_en_i);
  assign halt_pad_s = SEL_N'(ep_halt_i);
  assign nak_pad_s  = SEL_N'(fifo_nak_i);

  assign in_range_s = ep_in_range(sel_s, N_EPS);
  assign halted_s   = in_range_s & halt_pad_s[idx_s];
  assign legal_s    = in_range_s & en_pad_s[idx_s];

  // Halt outranks disable; both are judged only at the first byte.
  assign route_s = ~rst_i & (((state_q == IDLE) & legal_s & ~halted_s) | (state_q == ACTIVE));

  // Packet FSM: advances only on gated SIE strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ep_q    <= {EP_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (byte_s) begin
            ep_q <= out_ep_i;
            if (halted_s) begin
              state_q <= STALL;
            end else if (!legal_s) begin
              state_q <= REJECT;
            end else begin
              state_q <= ACTIVE;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        ACTIVE, REJECT, STALL: begin
          if (eop_s || err_s) begin
            state_q <= IDLE;
          end else begin
            state_q <= state_q;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Zero-latency routing keeps the FIFO's own strobe timing intact.
  always_comb begin
    fifo_valid_o = {N_EPS{1'b0}};
    fifo_err_o   = {N_EPS{1'b0}};
    fifo_ready_o = {N_EPS{1'b0}};
    for (int k = 0; k < N_EPS; k++) begin
      if (route_s && (idx_s == EP_W'(k))) begin
        fifo_valid_o[k] = out_valid_i;
        fifo_err_o[k]   = out_err_i;
        fifo_ready_o[k] = out_ready_i;
      end else begin
        fifo_valid_o[k] = 1'b0;
        fifo_err_o[k]   = 1'b0;
        fifo_ready_o[k] = 1'b0;
      end
    end
  end

  assign fifo_data_o = out_data_i;
  assign out_nak_o   = route_s ? nak_pad_s[idx_s] : (~rst_i & (state_q == REJECT));
  assign out_stall_o = ~rst_i & ((state_q == STALL) | ((state_q == IDLE) & halted_s));

`ifdef OUT_EP_CTRL_STATS_EN
  logic                 confirm_s;
  logic [STAT_W-1:0]    cnt_s [N_EPS];
  logic [STAT_W-1:0]    stat_mux_s;
  logic [STAT_W-1:0]    stat_q;

  assign confirm_s = eop_s & route_s & ~out_nak_o;

  for (genvar g = 0; g < N_EPS; g++) begin : g_cnt
    ep_pkt_counter u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (confirm_s & (idx_s == EP_W'(g))),
      .cnt_o (cnt_s[g])
    );
  end

  // Select the requested endpoint's counter; unknown endpoints read as zero.
  always_comb begin
    stat_mux_s = {STAT_W{1'b0}};
    for (int k = 0; k < N_EPS; k++) begin
      if (stat_sel_i == EP_W'(k + 1)) begin
        stat_mux_s = cnt_s[k];
      end else begin
        stat_mux_s = stat_mux_s;
      end
    end
  end

  // Registered statistics read port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_q <= {STAT_W{1'b0}};
    end else begin
      stat_q <= stat_mux_s;
    end
  end

  assign stat_cnt_o = stat_q;
`endif

endmodule

// File: tb/tb_out_ep_ctrl.sv
// Self-checking bench for out_ep_ctrl: directed vector table, randomized model check, optional stats.
module tb_out_ep_ctrl;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst, gate, valid, err, ready;
  logic [3:0]   ep;
  logic [7:0]   data;
  logic [N-1:0] en, halt, fnak;
  logic         nak_o, stall_o;
  logic [7:0]   fdata_o;
  logic [N-1:0] fvalid_o, ferr_o, fready_o;
  logic [3:0]   stat_sel;
  logic [15:0]  stat_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  out_ep_ctrl #(.N_EPS(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clk_gate_i   (gate),
    .out_ep_i     (ep),
    .out_data_i   (data),
    .out_valid_i  (valid),
    .out_err_i    (err),
    .out_ready_i  (ready),
    .out_nak_o    (nak_o),
    .out_stall_o  (stall_o),
    .ep_en_i      (en),
    .ep_halt_i    (halt),
    .fifo_data_o  (fdata_o),
    .fifo_valid_o (fvalid_o),
    .fifo_err_o   (ferr_o),
    .fifo_ready_o (fready_o),
    .fifo_nak_i   (fnak)
`ifdef OUT_EP_CTRL_STATS_EN
    ,
    .stat_sel_i   (stat_sel),
    .stat_cnt_o   (stat_cnt)
`endif
  );

  typedef struct {
    logic       rst;
    logic       gate;
    logic [3:0] ep;
    logic       v, e, r;
    logic [1:0] en, halt, fnak;
    logic [1:0] xv, xe, xr;
    logic       xnak, xstall;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic r_rst, input logic r_gate, input logic [3:0] r_ep,
                              input logic r_v, input logic r_e, input logic r_r,
                              input logic [1:0] r_en, input logic [1:0] r_halt, input logic [1:0] r_fnak,
                              input logic [1:0] r_xv, input logic [1:0] r_xe, input logic [1:0] r_xr,
                              input logic r_xnak, input logic r_xstall);
    vec_t t;
    t.rst = r_rst; t.gate = r_gate; t.ep = r_ep; t.v = r_v; t.e = r_e; t.r = r_r;
    t.en = r_en; t.halt = r_halt; t.fnak = r_fnak;
    t.xv = r_xv; t.xe = r_xe; t.xr = r_xr; t.xnak = r_xnak; t.xstall = r_xstall;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pack_out();
    return {fvalid_o, ferr_o, fready_o, nak_o, stall_o};
  endfunction

  // Reference model: packet in flight, its endpoint and its disposition.
  bit m_busy;
  int m_ep;
  int m_kind;  // 1 deliver, 2 reject, 3 stall
  int m_cnt[N];

  function automatic logic [7:0] model_out();
    int sel;
    bit inr, halted, legal, route, n, s;
    logic [1:0] v2, e2, r2;
    v2 = 2'b00; e2 = 2'b00; r2 = 2'b00; n = 1'b0; s = 1'b0;
    if (!rst) begin
      sel    = m_busy ? m_ep : int'(ep);
      inr    = (sel >= 1) && (sel <= N);
      halted = inr && halt[sel-1];
      legal  = inr && en[sel-1];
      route  = m_busy ? (m_kind == 1) : (legal && !halted);
      if (route) begin
        v2[sel-1] = valid; e2[sel-1] = err; r2[sel-1] = ready;
        n = fnak[sel-1];
      end else begin
        n = m_busy && (m_kind == 2);
      end
      s = m_busy ? (m_kind == 3) : halted;
    end
    return {v2, e2, r2, n, s};
  endfunction

  task automatic model_step();
    int sel;
    bit inr, halted, legal;
    if (rst) begin
      m_busy = 1'b0;
    end else if (gate && ready) begin
      if (err || !valid) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        sel    = int'(ep);
        inr    = (sel >= 1) && (sel <= N);
        halted = inr && halt[sel-1];
        legal  = inr && en[sel-1];
        m_busy = 1'b1;
        m_ep   = sel;
        m_kind = halted ? 3 : (legal ? 1 : 2);
      end
    end
  endtask

  task automatic drive(input logic r_rst, input logic [3:0] r_ep, input logic r_v,
                       input logic r_e, input logic r_r, input logic [1:0] r_fnak);
    @(negedge clk);
    rst = r_rst; gate = 1'b1; ep = r_ep; valid = r_v; err = r_e; ready = r_r; fnak = r_fnak;
    data = 8'($urandom);
  endtask

  initial begin
    rst = 1'b1; gate = 1'b1; ep = 4'd0; data = 8'd0; valid = 1'b0; err = 1'b0; ready = 1'b0;
    en = 2'b11; halt = 2'b00; fnak = 2'b00; stat_sel = 4'd0;
    m_busy = 1'b0; m_ep = 0; m_kind = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;

    //           rst gate ep   v  e  r  en     halt   fnak   xv     xe     xr     nak  stall
    tv.push_back(mk(1, 1, 4'd2, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 1, 4'd2, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0));
    tv.push_back(mk(0, 1, 4'd2, 1, 0, 0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 1, 4'd2, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0));
    tv.push_back(mk(0, 1, 4'd2, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 0, 0));
    tv.push_back(mk(0, 1, 4'd1, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 0, 0));
    tv.push_back(mk(0, 1, 4'd1, 1, 0, 1, 2'b11, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 1, 0));
    tv.push_back(mk(0, 1, 4'd1, 1, 0, 0, 2'b11, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 1, 0));
    tv.push_back(mk(0, 1, 4'd1, 0, 0, 1, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1, 0));
    tv.push_back(mk(0, 1, 4'd1, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 1, 4'd3, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 1, 4'd3, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
    tv.push_back(mk(0, 1, 4'd3, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
    tv.push_back(mk(0, 1, 4'd3, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
    tv.push_back(mk(0, 1, 4'd3, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
    tv.push_back(mk(0, 1, 4'd3, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 1, 4'd1, 1, 0, 1, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
    tv.push_back(mk(0, 1, 4'd1, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
    tv.push_back(mk(0, 1, 4'd1, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
    tv.push_back(mk(0, 1, 4'd1, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 1, 4'd2, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0));
    tv.push_back(mk(0, 1, 4'd2, 1, 1, 1, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 0, 0));
    tv.push_back(mk(0, 1, 4'd3, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 1, 4'd2, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0));
    tv.push_back(mk(1, 1, 4'd2, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 1, 4'd3, 1, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 0, 4'd1, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 0, 0));
    tv.push_back(mk(0, 1, 4'd3, 1, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 1, 4'd2, 1, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 1, 4'd2, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));
    tv.push_back(mk(0, 1, 4'd2, 0, 0, 1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
    tv.push_back(mk(0, 1, 4'd2, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 1, 4'd1, 0, 0, 1, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1, 0));
    tv.push_back(mk(0, 1, 4'd3, 1, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 1, 4'd0, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0));
    tv.push_back(mk(0, 1, 4'd0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst = tv[i].rst; gate = tv[i].gate; ep = tv[i].ep; valid = tv[i].v; err = tv[i].e;
      ready = tv[i].r; en = tv[i].en; halt = tv[i].halt; fnak = tv[i].fnak;
      data = 8'($urandom);
      #1;
      check($sformatf("vec%0d", i), 32'(pack_out()),
            32'({tv[i].xv, tv[i].xe, tv[i].xr, tv[i].xnak, tv[i].xstall}));
      check($sformatf("vec%0d_data", i), 32'(fdata_o), 32'(data));
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 99) == 0);
      gate  = ($urandom_range(0, 3) != 0);
      ep    = 4'($urandom_range(0, 3));
      valid = ($urandom_range(0, 3) != 0);
      err   = ($urandom_range(0, 19) == 0);
      ready = $urandom_range(0, 1) == 1;
      en    = 2'($urandom);
      halt  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      fnak  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      data  = 8'($urandom);
      #1;
      check($sformatf("rand%0d", c), 32'(pack_out()), 32'(model_out()));
      @(posedge clk);
      model_step();
    end

`ifdef OUT_EP_CTRL_STATS_EN
    en = 2'b11; halt = 2'b00;
    drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
    for (int p = 0; p < 3; p++) begin
      drive(1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 2'b00);
      drive(1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 2'b00);
      drive(1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 2'b00);
    end
    drive(1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 2'b00);
    drive(1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 2'b01);
    drive(1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 2'b00);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    stat_sel = 4'd1;
    @(posedge clk); #1;
    check("stat_ep1", 32'(stat_cnt), 32'd3);
    @(negedge clk); stat_sel = 4'd2;
    @(posedge clk); #1;
    check("stat_ep2", 32'(stat_cnt), 32'd1);
    @(negedge clk); stat_sel = 4'd0;
    @(posedge clk); #1;
    check("stat_sel0", 32'(stat_cnt), 32'd0);
    @(negedge clk); stat_sel = 4'd3;
    @(posedge clk); #1;
    check("stat_sel3", 32'(stat_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
